prng_lfsr_wb: RTL and testbench

Parametrised XNOR-feedback LFSR pseudo-random generator on the Wishbone slave port of the user project. It produces OUT_BITS bits per step, packs them into 32-bit words behind a one-word buffer with backpressure, and supports runtime seeding, lockup recovery and a word-ready interrupt. It replaces the fixed 168-bit, 3-output generator as the user-area PRNG.

---
 rtl/prng_pkg.sv | 24 ++
 rtl/prng_lfsr_wb_if.sv | 22 ++
 rtl/prng_lfsr_core.sv | 47 ++++
 rtl/prng_lfsr_wb.sv | 193 +++++++++++++++++++
 tb/tb_prng_lfsr_wb.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared register map, bit positions and packing helper for the Wishbone LFSR
// random-number generator.
package prng_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_SEED   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_VALID     = 0;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_LOCKUP    = 2;
  localparam int ST_COUNT_LSB = 16;
  localparam int ST_COUNT_W   = 16;

  // Steps needed to fill a 32-bit word, rounded up.
  function automatic int steps_per_word(input int out_bits);
    return (32 + out_bits - 1) / out_bits;
  endfunction

endpackage

// File: rtl/prng_lfsr_wb_if.sv
// Wishbone slave bundle for the LFSR generator; the user-project top drives the
// master side, the generator takes the slave side.
interface prng_lfsr_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/prng_lfsr_core.sv
// XNOR-feedback LFSR: multi-bit step, all-ones lockup escape and 32-bit seed
// shift-in. Emits the bits inserted by the current step.
module prng_lfsr_core #(
  parameter int               WIDTH      = 168,
  parameter int               OUT_BITS   = 3,
  parameter int               TAP_STRIDE = 32,
  parameter logic [WIDTH-1:0] SEED_INIT  = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_step,
  input  logic                i_seed_we,
  input  logic [31:0]         i_seed_dat,
  output logic [OUT_BITS-1:0] o_fb,
  output logic                o_lockup_pulse
);

  localparam logic [OUT_BITS-1:0] LSB_MASK = OUT_BITS'(1);

  logic [WIDTH-1:0]    r_lfsr;
  logic [OUT_BITS-1:0] w_fb_raw;
  logic                w_all_ones;

  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_fb
    assign w_fb_raw[gi] = ~(r_lfsr[WIDTH-1-gi]
                          ^ r_lfsr[WIDTH-1-gi-TAP_STRIDE]
                          ^ r_lfsr[WIDTH-1-gi-2*TAP_STRIDE]
                          ^ r_lfsr[WIDTH-1-gi-3*TAP_STRIDE]);
  end

  // All-ones maps to itself under XNOR; clearing the bit that lands in
  // position 0 is enough to leave the fixed point.
  assign w_all_ones     = &r_lfsr;
  assign o_fb           = w_all_ones ? (w_fb_raw & ~LSB_MASK) : w_fb_raw;
  assign o_lockup_pulse = i_step & w_all_ones;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED_INIT;
    end else if (i_seed_we) begin
      r_lfsr <= {r_lfsr[WIDTH-33:0], i_seed_dat};
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[WIDTH-1-OUT_BITS:0], o_fb};
    end
  end

endmodule

// File: rtl/prng_lfsr_wb.sv
// Wishbone-attached LFSR generator: register decode, word packer with a
// one-word buffer and backpressure, sticky status flags and interrupt.
module prng_lfsr_wb
  import prng_pkg::*;
#(
  parameter int           WIDTH      = 168,
  parameter int           OUT_BITS   = 3,
  parameter int           TAP_STRIDE = 32,
  parameter logic [255:0] SEED_INIT  = 256'hE3074618_6853_97B33A_02183540_34B1E6_862E08C005C1_83
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  prng_lfsr_wb_if.slave       wbs,
  output logic [OUT_BITS-1:0] io_out,
  output logic [OUT_BITS-1:0] io_oeb,
  output logic                irq_o
);

  localparam int            K         = steps_per_word(OUT_BITS);
  localparam int            CW        = $clog2(K);
  localparam logic [CW-1:0] LAST_STEP = CW'(K - 1);

  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_en;
  logic                  r_irq_en;
  logic [31:0]           r_acc;
  logic [CW-1:0]         r_step_cnt;
  logic [31:0]           r_buf;
  logic                  r_word_valid;
  logic [ST_COUNT_W-1:0] r_word_count;
  logic                  r_underflow;
  logic                  r_lockup;
  logic [OUT_BITS-1:0]   r_io_out;

  logic                  w_req;
  logic                  w_rd;
  logic                  w_wr;
  logic [1:0]            w_reg;
  logic                  w_data_rd;
  logic                  w_status_wr;
  logic                  w_seed_we;
  logic                  w_hold;
  logic                  w_step;
  logic                  w_word_done;
  logic [OUT_BITS-1:0]   w_fb;
  logic                  w_lockup_pulse;
  logic [31:0]           w_acc_next;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // Wishbone: a request is cyc&stb sampled on an edge while ack is low. ack is
  // high for exactly the following cycle with registered read data, and every
  // register side effect commits on that sampling edge.
  assign w_req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_wr        = w_req & wbs.wbs_we_i;
  assign w_rd        = w_req & ~wbs.wbs_we_i;
  assign w_reg       = wbs.wbs_adr_i[3:2];
  assign w_data_rd   = w_rd & (w_reg == REG_DATA);
  assign w_status_wr = w_wr & (w_reg == REG_STATUS);
  assign w_seed_we   = w_wr & (w_reg == REG_SEED) & ~r_en;

  assign w_unused = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0]};

  // The last step of a word waits while the buffer is full, unless the buffer
  // is being read on this very edge.
  assign w_hold      = r_word_valid & (r_step_cnt == LAST_STEP) & ~w_data_rd;
  assign w_step      = r_en & ~w_hold;
  assign w_word_done = w_step & (r_step_cnt == LAST_STEP);
  assign w_acc_next  = {r_acc[31-OUT_BITS:0], w_fb};

  prng_lfsr_core #(
    .WIDTH      (WIDTH),
    .OUT_BITS   (OUT_BITS),
    .TAP_STRIDE (TAP_STRIDE),
    .SEED_INIT  (SEED_INIT[WIDTH-1:0])
  ) u_core (
    .i_clk          (wb_clk_i),
    .i_rst_n        (wb_rst_ni),
    .i_step         (w_step),
    .i_seed_we      (w_seed_we),
    .i_seed_dat     (wbs.wbs_dat_i),
    .o_fb           (w_fb),
    .o_lockup_pulse (w_lockup_pulse)
  );

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      REG_DATA: begin
        w_rdata = r_word_valid ? r_buf : '0;
      end
      REG_STATUS: begin
        w_rdata[ST_VALID]                   = r_word_valid;
        w_rdata[ST_UNDERFLOW]               = r_underflow;
        w_rdata[ST_LOCKUP]                  = r_lockup;
        w_rdata[ST_COUNT_LSB +: ST_COUNT_W] = r_word_count;
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_dat <= w_rd ? w_rdata : '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr && (w_reg == REG_CTRL)) begin
      r_en     <= wbs.wbs_dat_i[CTRL_EN];
      r_irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_acc        <= '0;
      r_step_cnt   <= '0;
      r_buf        <= '0;
      r_word_valid <= 1'b0;
      r_word_count <= '0;
    end else if (w_seed_we) begin
      r_acc        <= '0;
      r_step_cnt   <= '0;
      r_word_valid <= 1'b0;
    end else begin
      if (w_word_done) begin
        r_buf        <= w_acc_next;
        r_acc        <= '0;
        r_step_cnt   <= '0;
        r_word_count <= r_word_count + 16'd1;
      end else if (w_step) begin
        r_acc      <= w_acc_next;
        r_step_cnt <= r_step_cnt + CW'(1);
      end
      // A word completing on a read edge refills the buffer, so valid stays set.
      if (w_word_done) begin
        r_word_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_underflow <= 1'b0;
      r_lockup    <= 1'b0;
    end else begin
      if (w_data_rd && !r_word_valid) begin
        r_underflow <= 1'b1;
      end else if (w_status_wr && wbs.wbs_dat_i[ST_UNDERFLOW]) begin
        r_underflow <= 1'b0;
      end
      if (w_lockup_pulse) begin
        r_lockup <= 1'b1;
      end else if (w_status_wr && wbs.wbs_dat_i[ST_LOCKUP]) begin
        r_lockup <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_io_out <= '0;
    end else if (w_step) begin
      r_io_out <= w_fb;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign io_out        = r_io_out;
  assign io_oeb        = r_en ? '0 : '1;
  assign irq_o         = r_word_valid & r_irq_en;

endmodule

// File: tb/tb_prng_lfsr_wb.sv
// Bench for prng_lfsr_wb: a bit-stream model of the generator with a word
// buffer drives an expected-read queue and per-cycle pin checks.
module tb_prng_lfsr_wb;
  import prng_pkg::*;

  localparam int           W    = 168;
  localparam int           OB   = 3;
  localparam int           TS   = 32;
  localparam int           K    = 11;
  localparam logic [255:0] SEED = 256'hE3074618_6853_97B33A_02183540_34B1E6_862E08C005C1_83;

  logic          clk;
  logic          rst_n;
  logic [OB-1:0] io_out;
  logic [OB-1:0] io_oeb;
  logic          irq_o;

  prng_lfsr_wb_if wb ();

  prng_lfsr_wb dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (wb),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_words[4];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within 2ms");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // XNOR of four taps is 1 exactly when an even number of them are 1.
  function automatic logic [OB-1:0] model_fb(input logic [W-1:0] s);
    logic [OB-1:0] f;
    logic [7:0]    idx;
    int            ones;
    f = '0;
    for (int i = 0; i < OB; i++) begin
      ones = 0;
      for (int k = 0; k < 4; k++) begin
        idx = 8'(W - 1 - i - k * TS);
        if (s[idx]) ones++;
      end
      f[i] = ((ones % 2) == 0);
    end
    if (s == {W{1'b1}}) f[0] = 1'b0;
    return f;
  endfunction

  logic [W-1:0]  m_lfsr;
  logic [31:0]   m_acc, m_buf;
  int            m_steps;
  logic          m_valid, m_under, m_lock, m_en, m_irq_en, m_ack;
  logic [15:0]   m_cnt;
  logic [OB-1:0] m_io;

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0]  s;
    logic [31:0]   acc, bufw, rdat, d;
    int            steps;
    logic          valid, under, lock, en, irq_en, req, rd, wr, go;
    logic [15:0]   cnt;
    logic [OB-1:0] fb, io;
    logic [1:0]    a;
    if (!rst_n) begin
      m_lfsr <= SEED[W-1:0];
      m_acc <= '0; m_buf <= '0; m_steps <= 0;
      m_valid <= 1'b0; m_under <= 1'b0; m_lock <= 1'b0;
      m_en <= 1'b0; m_irq_en <= 1'b0; m_ack <= 1'b0;
      m_cnt <= '0; m_io <= '0;
    end else begin
      s = m_lfsr; acc = m_acc; bufw = m_buf; steps = m_steps;
      valid = m_valid; under = m_under; lock = m_lock;
      en = m_en; irq_en = m_irq_en; cnt = m_cnt; io = m_io;
      req = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack;
      rd  = req && !wb.wbs_we_i;
      wr  = req && wb.wbs_we_i;
      a   = wb.wbs_adr_i[3:2];
      d   = wb.wbs_dat_i;
      if (rd) begin
        case (a)
          2'd0:    rdat = {30'd0, irq_en, en};
          2'd2:    rdat = valid ? bufw : 32'd0;
          2'd3:    rdat = {cnt, 13'd0, lock, under, valid};
          default: rdat = 32'd0;
        endcase
        exp_q.push_back(rdat);
      end
      go = en && !(valid && steps == K - 1 && !(rd && a == 2'd2));
      if (rd && a == 2'd2) begin
        if (valid) valid = 1'b0;
        else under = 1'b1;
      end
      if (wr && a == 2'd3) begin
        if (d[1]) under = 1'b0;
        if (d[2]) lock = 1'b0;
      end
      if (wr && a == 2'd1 && !en) begin
        s = {s[W-33:0], d};
        acc = '0; steps = 0; valid = 1'b0;
      end
      if (go) begin
        if (s == {W{1'b1}}) lock = 1'b1;
        fb = model_fb(s);
        s = {s[W-OB-1:0], fb};
        io = fb;
        acc = (acc << OB) | 32'(fb);
        steps++;
        if (steps == K) begin
          bufw = acc; valid = 1'b1; cnt = cnt + 16'd1; acc = '0; steps = 0;
        end
      end
      if (wr && a == 2'd0) begin
        en = d[0]; irq_en = d[1];
      end
      m_lfsr <= s; m_acc <= acc; m_buf <= bufw; m_steps <= steps;
      m_valid <= valid; m_under <= under; m_lock <= lock;
      m_en <= en; m_irq_en <= irq_en; m_ack <= req; m_cnt <= cnt; m_io <= io;
    end
  end

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", 32'(wb.wbs_ack_o), 32'(m_ack));
      check("io_out", 32'(io_out), 32'(m_io));
      check("io_oeb", 32'(io_oeb), m_en ? 32'd0 : 32'(3'b111));
      check("irq", 32'(irq_o), 32'(m_valid & m_irq_en));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] q);
    int n;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = {28'd0, a, 2'b00};
    wb.wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    if (!wb.wbs_ack_o) check("ack_timeout", 32'd0, 32'd1);
    q = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] q);
    wb_access(1'b0, a, 32'd0, q);
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
    else check("rd_data", q, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0]   q;
    logic [W-1:0]  s;
    logic [31:0]   acc;
    logic [OB-1:0] f, held;

    s = SEED[W-1:0];
    for (int w = 0; w < 4; w++) begin
      acc = '0;
      for (int k = 0; k < K; k++) begin
        f = model_fb(s);
        s = {s[W-OB-1:0], f};
        acc = (acc << OB) | 32'(f);
      end
      ref_words[w] = acc;
    end

    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;

    // Reset state
    check("rst_oeb", 32'(io_oeb), 32'(3'b111));
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    wb_read(REG_STATUS, q); check("rst_status", q, 32'd0);
    wb_read(REG_CTRL, q);   check("rst_ctrl", q, 32'd0);

    // First word from SEED_INIT; first step bits worked out by hand from the seed
    wb_write(REG_CTRL, 32'h1);
    idle(1);
    check("first_step_bits", 32'(io_out), 32'(3'b001));
    idle(12);
    wb_read(REG_STATUS, q);
    check("w1_count", 32'(q[31:16]), 32'd1);
    check("w1_valid", 32'(q[0]), 32'd1);
    wb_read(REG_DATA, q); check("w1_word", q, ref_words[0]);

    // No reads for 40 cycles: one word buffered, generator stalled
    idle(40);
    wb_read(REG_STATUS, q);
    check("stall_count", 32'(q[31:16]), 32'd2);
    check("stall_valid", 32'(q[0]), 32'd1);
    held = io_out;
    idle(5);
    check("stall_io_held", 32'(io_out), 32'(held));
    wb_read(REG_DATA, q); check("w2_word", q, ref_words[1]);
    wb_read(REG_STATUS, q); check("drain_count", 32'(q[31:16]), 32'd3);
    wb_read(REG_DATA, q); check("w3_word", q, ref_words[2]);

    // Underflow and its write-1-to-clear
    wb_write(REG_CTRL, 32'h0);
    wb_read(REG_DATA, q);
    wb_read(REG_DATA, q); check("underflow_data", q, 32'd0);
    wb_read(REG_STATUS, q); check("underflow_set", 32'(q[1]), 32'd1);
    wb_write(REG_STATUS, 32'h2);
    wb_read(REG_STATUS, q); check("underflow_clr", 32'(q[1]), 32'd0);

    // Seed all-ones: lockup escape
    for (int i = 0; i < 6; i++) wb_write(REG_SEED, 32'hFFFF_FFFF);
    wb_write(REG_CTRL, 32'h1);
    idle(1);
    check("lock_step1", 32'(io_out), 32'(3'b110));
    idle(1);
    check("lock_step2", 32'(io_out), 32'(3'b111));
    idle(12);
    wb_read(REG_STATUS, q); check("lockup_set", 32'(q[2]), 32'd1);
    wb_read(REG_DATA, q); check("lock_word1", q, 32'hBFFF_FFFF);
    idle(14);
    wb_read(REG_DATA, q); check("lock_word2", q, 32'hFFFF_FFFF);
    idle(14);
    wb_read(REG_DATA, q);
    wb_write(REG_STATUS, 32'h4);
    wb_read(REG_STATUS, q); check("lockup_clr", 32'(q[2]), 32'd0);

    // Seed all-zeros with interrupt enabled
    wb_write(REG_CTRL, 32'h0);
    for (int i = 0; i < 6; i++) wb_write(REG_SEED, 32'h0);
    wb_write(REG_CTRL, 32'h3);
    idle(14);
    check("irq_on", 32'(irq_o), 32'd1);
    wb_read(REG_DATA, q); check("zero_word1", q, 32'hFFFF_FFFF);
    idle(14);
    check("irq_before_rst", 32'(irq_o), 32'd1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_irq", 32'(irq_o), 32'd0);
    check("async_oeb", 32'(io_oeb), 32'(3'b111));
    check("async_io_out", 32'(io_out), 32'd0);
    check("async_ack", 32'(wb.wbs_ack_o), 32'd0);
    idle(2);
    #2 rst_n = 1'b1;

    // Restart from SEED_INIT; a SEED write while running is ignored
    wb_write(REG_CTRL, 32'h1);
    idle(1);
    check("restart_step", 32'(io_out), 32'(3'b001));
    idle(12);
    wb_read(REG_DATA, q); check("restart_word1", q, ref_words[0]);
    wb_write(REG_SEED, 32'h1234_5678);
    idle(14);
    wb_read(REG_DATA, q); check("seed_ignored_word2", q, ref_words[1]);
    wb_read(REG_CTRL, q); check("ctrl_readback", q, 32'h1);

    idle(2);
    if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
